// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button 2-FF synchroniser and debouncer with level/press/release outputs.
// Optional auto-repeat on held buttons is enabled by defining BTN_AUTOREPEAT_EN.
module btn_debounce #(
  parameter int NUM_BTNS        = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [NUM_BTNS-1:0] s1;
  logic [NUM_BTNS-1:0] s2;
  logic [NUM_BTNS-1:0] accept;
  logic [CW-1:0]       cnt [NUM_BTNS];

  // A change is accepted on the edge that completes the run of mismatching samples.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      accept[i] = (s2[i] != btn_level[i]) && (cnt[i] == CNT_MAX);
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] RD_MAX = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_MAX = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0]       rcnt [NUM_BTNS];
  logic [NUM_BTNS-1:0] rfirst;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1          <= '0;
      s2          <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
        cnt[i] <= '0;
      end
`ifdef BTN_AUTOREPEAT_EN
      rfirst <= '1;
      for (int i = 0; i < NUM_BTNS; i++) begin
        rcnt[i] <= '0;
      end
`endif
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      for (int i = 0; i < NUM_BTNS; i++) begin
        btn_press[i]   <= 1'b0;
        btn_release[i] <= 1'b0;
        if (s2[i] == btn_level[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cnt[i]         <= '0;
          btn_level[i]   <= s2[i];
          btn_press[i]   <= s2[i];
          btn_release[i] <= ~s2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
`ifdef BTN_AUTOREPEAT_EN
        // The repeat timer restarts on every press acceptance and idles while released.
        if (!btn_level[i] || accept[i]) begin
          rcnt[i]   <= '0;
          rfirst[i] <= 1'b1;
        end else if (rcnt[i] == (rfirst[i] ? RD_MAX : RP_MAX)) begin
          rcnt[i]      <= '0;
          rfirst[i]    <= 1'b0;
          btn_press[i] <= 1'b1;
        end else begin
          rcnt[i] <= rcnt[i] + 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - randomized and directed bench for btn_debounce against a delay-line/window model.
module tb_btn_debounce;
  localparam int N  = 5;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_level = '0;
  logic [N-1:0] exp_press = '0;
  logic [N-1:0] exp_release = '0;
  logic [N-1:0] rq[$];
  int           e = 0;
  int           pedge [N];

  btn_debounce #(
    .NUM_BTNS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout sim did not finish");
    $fatal(1, "timeout");
  end

  // Synchronised view before edge j is the raw value two edges earlier.
  function automatic logic [N-1:0] s2_before(int j);
    if (j < 2) return '0;
    return rq[j-2];
  endfunction

  // Level flips when the last D synchronised samples all disagree with it.
  task automatic model_edge();
    rq.push_back(btn_raw);
    exp_press   = '0;
    exp_release = '0;
    for (int b = 0; b < N; b++) begin
      logic acc;
      int   d;
      acc = 1'b1;
      for (int j = e - D + 1; j <= e; j++) begin
        if (j < 0) acc = 1'b0;
        else if (s2_before(j)[b] == exp_level[b]) acc = 1'b0;
      end
      if (acc) begin
        exp_level[b] = ~exp_level[b];
        if (exp_level[b]) begin
          exp_press[b] = 1'b1;
          pedge[b] = e;
        end else begin
          exp_release[b] = 1'b1;
        end
      end else if (exp_level[b]) begin
        d = e - pedge[b];
`ifdef BTN_AUTOREPEAT_EN
        if (d == RD || (d > RD && ((d - RD) % RP) == 0)) exp_press[b] = 1'b1;
`else
        if (d < 0) exp_press[b] = 1'b0;
`endif
      end
    end
    e++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    checks++;
    if (btn_level !== exp_level || btn_press !== exp_press || btn_release !== exp_release) begin
      errors++;
      $display("FAIL tick e=%0d level=%b exp=%b press=%b exp=%b release=%b exp=%b",
               e, btn_level, exp_level, btn_press, exp_press, btn_release, exp_release);
    end
  endtask

  task automatic enter_reset();
    rst = 1'b0;
    exp_level = '0;
    exp_press = '0;
    exp_release = '0;
    rq.delete();
    e = 0;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release} !== '0) begin
      errors++;
      $display("FAIL async_reset outputs=%b required 0", {btn_level, btn_press, btn_release});
    end
  endtask

  task automatic idle(int n);
    btn_raw = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    int first;
    btn_raw = '1;
    enter_reset();
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    first = -1;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (btn_press != '0 && first < 0) begin
        first = k;
        checks++;
        if (btn_press !== 5'b11111 || btn_level !== 5'b11111) begin
          errors++;
          $display("FAIL reset_release_press press=%b level=%b required 11111", btn_press, btn_level);
        end
      end
    end
    checks++;
    if (first != D + 1) begin
      errors++;
      $display("FAIL reset_release_edge got=%0d required=%0d", first, D + 1);
    end
    idle(12);
  endtask

  task automatic test_clean_press();
    int first;
    first = -1;
    btn_raw = 5'b00100;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (btn_press[2] && first < 0) first = k;
      if (k == D + 2) begin
        checks++;
        if (btn_press[2] !== 1'b0 || btn_level !== 5'b00100) begin
          errors++;
          $display("FAIL clean_press_after press2=%b level=%b required 0/00100", btn_press[2], btn_level);
        end
      end
    end
    checks++;
    if (first != D + 1) begin
      errors++;
      $display("FAIL clean_press_edge got=%0d required=%0d", first, D + 1);
    end
    idle(12);
  endtask

  task automatic test_glitch();
    int pulses;
    logic [7:0] pat;
    pulses = 0;
    pat = 8'b01110111;
    for (int k = 0; k < 20; k++) begin
      btn_raw = (k < 7) ? {4'b0, pat[k]} : '0;
      tick();
      if (btn_press[0] || btn_release[0] || btn_level[0]) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL glitch_reject active_cycles=%0d required=0", pulses);
    end
  endtask

  task automatic test_simultaneous();
    int p1, p3, r1, r3;
    p1 = -1; p3 = -1; r1 = -1; r3 = 0;
    btn_raw = 5'b01010;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (btn_press[1] && p1 < 0) p1 = k;
      if (btn_press[3] && p3 < 0) p3 = k;
    end
    checks++;
    if (p1 != D + 1 || p3 != D + 1) begin
      errors++;
      $display("FAIL simultaneous_press p1=%0d p3=%0d required=%0d", p1, p3, D + 1);
    end
    btn_raw = 5'b01000;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (btn_release[1] && r1 < 0) r1 = k;
      if (btn_release[3]) r3++;
    end
    checks++;
    if (r1 != D + 1 || r3 != 0) begin
      errors++;
      $display("FAIL single_release r1=%0d required=%0d r3_count=%0d required=0", r1, D + 1, r3);
    end
    idle(12);
  endtask

  task automatic test_reset_mid_debounce();
    int early, first;
    early = 0; first = -1;
    btn_raw = 5'b10000;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (btn_press != '0 || btn_level != '0) early++;
    end
    enter_reset();
    for (int k = 0; k < 2; k++) begin
      tick();
      if (btn_press != '0 || btn_level != '0) early++;
    end
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (btn_press[4] && first < 0) first = k;
    end
    checks++;
    if (early != 0 || first != D + 1) begin
      errors++;
      $display("FAIL reset_mid_debounce early=%0d required=0 first=%0d required=%0d", early, first, D + 1);
    end
    idle(12);
  endtask

  task automatic test_autorepeat();
    int got[$];
    int expq[$];
    int rel, late;
    rel = 0; late = 0;
`ifdef BTN_AUTOREPEAT_EN
    expq = '{D + 1, D + 1 + RD, D + 1 + RD + RP, D + 1 + RD + 2 * RP};
`else
    expq = '{D + 1};
`endif
    btn_raw = 5'b00100;
    for (int k = 0; k < D + 2 + RD + 2 * RP; k++) begin
      tick();
      if (btn_press[2]) got.push_back(k);
    end
    checks++;
    if (got != expq) begin
      errors++;
      $display("FAIL autorepeat_edges got=%p required=%p", got, expq);
    end
    btn_raw = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rel > 0 && btn_press[2]) late++;
      if (btn_release[2]) rel++;
    end
    checks++;
    if (rel != 1 || late != 0) begin
      errors++;
      $display("FAIL autorepeat_release releases=%0d required=1 late_presses=%0d required=0", rel, late);
    end
  endtask

  task automatic test_random();
    int hold [N];
    for (int b = 0; b < N; b++) hold[b] = 0;
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < N; b++) begin
        if (hold[b] == 0) begin
          btn_raw[b] = 1'($urandom_range(0, 1));
          hold[b] = $urandom_range(1, 9);
        end
        hold[b]--;
      end
      tick();
    end
    idle(12);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_reset_mid_debounce();
    test_autorepeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_debounce.md
# btn_debounce

Board-button front end: synchronises the raw push-button inputs (BTNU/BTNL/BTNC/BTNR/BTND) into the `clk` domain and debounces each one independently. Produces a clean level, a one-cycle press pulse and a one-cycle release pulse per button. Sits directly upstream of `select_btn_action`, which consumes the cleaned levels and pulses instead of raw pins.

## Interface
- `NUM_BTNS`, 5: number of independent buttons. Bit order is U, L, C, R, D (bit 0 = U).
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a change (5 ms at 100 MHz). Must be ≥1.
- `REPEAT_DELAY`, 50000000: cycles from press to first auto-repeat (used only with `BTN_AUTOREPEAT_EN`). Must be ≥1.
- `REPEAT_PERIOD`, 10000000: cycles between subsequent auto-repeats (used only with `BTN_AUTOREPEAT_EN`). Must be ≥1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `btn_raw`  in  NUM_BTNS  raw pad inputs, active-high, asynchronous to `clk`.
- `btn_level`  out  NUM_BTNS  debounced, registered button state.
- `btn_press`  out  NUM_BTNS  one-cycle pulse per accepted press; also auto-repeat pulses.
- `btn_release`  out  NUM_BTNS  one-cycle pulse per accepted release.

## Operation
- Per button: a 2-FF synchroniser (`s1`, `s2`), a stable register (drives `btn_level`) and a counter of width `$clog2(DEBOUNCE_CYCLES)` (minimum 1).
- At each edge:
  - `s2 == stable`: the counter clears.
  - `s2 != stable` and counter == `DEBOUNCE_CYCLES-1`: `stable <= s2`, counter clears, and the matching `btn_press` (rising) or `btn_release` (falling) pulses high for exactly that cycle.
  - Otherwise the counter increments.
- Glitch rejection: a mismatch lasting fewer than `DEBOUNCE_CYCLES` sampled cycles clears the counter and produces no output change.
- Buttons are fully independent. Any combination may pulse in the same cycle.
- `btn_press` and `btn_release` for one button are never high together.
- Reset (`rst` low, asynchronous):
  - Clears `s1`, `s2`, `stable`, all counters and all pulse registers.
  - All outputs read 0 while in reset.
  - No pulse is produced by reset assertion or deassertion.
  - A button held through reset is seen as a fresh press, `DEBOUNCE_CYCLES+1` edges after reset release.
- Reset during an in-progress debounce discards it, with no partial pulse.

## Timing
- All outputs are registered. There is no combinational path from `btn_raw`.
- Latency: if `btn_raw` changes and holds before edge 0 (the first sampling edge into `s1`), then:
  - `s2` updates at edge 1.
  - `btn_level` and the pulse update at edge `DEBOUNCE_CYCLES+1`.
  - Example: `DEBOUNCE_CYCLES`=4 → edge 5.
- Each pulse width is exactly one `clk` cycle.
- Minimum accepted event spacing is `DEBOUNCE_CYCLES` cycles per button.
- Counter width is sized so that `DEBOUNCE_CYCLES-1` fits. The counter never wraps, because it clears on match.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - Each button gets an extra repeat counter, active while `btn_level` is high.
  - A press accepted at edge P gives extra `btn_press` pulses at edges P+`REPEAT_DELAY`, then every `REPEAT_PERIOD` edges after that.
  - Release, or reset, clears the counter immediately, and no further repeats follow.
  - `btn_release` never repeats.
- `BTN_AUTOREPEAT_EN` undefined:
  - No repeat logic is synthesised and the `REPEAT_*` parameters are ignored.
  - Exactly one `btn_press` per accepted rising edge.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
- Reset values: hold `rst`=0 with `btn_raw`=5'b11111 → all outputs 0. Release reset → `btn_level`=5'b11111 and `btn_press`=5'b11111 for one cycle at edge 5 after release, no earlier.
- Clean press: raise `btn_raw[2]` (C) before edge 0 and hold → `btn_level[2]`=1 and `btn_press[2]`=1 at edge 5. `btn_press[2]` is 0 at edge 6. No other bits change.
- Glitch rejection: pulse `btn_raw[0]` high for 3 cycles, low for 1, high for 3, then low → `btn_level[0]` stays 0 and no pulses occur.
- Simultaneous: raise `btn_raw[1]` and `btn_raw[3]` in the same cycle → both press bits pulse on the same edge. Drop `btn_raw[1]` 10 cycles later → only `btn_release[1]` pulses, 5 edges after the drop.
- Reset mid-debounce: raise `btn_raw[4]`, assert `rst` at edge 3, release at edge 6 → no pulse before release. `btn_press[4]` pulses at edge 5 after release.
- Auto-repeat (with `BTN_AUTOREPEAT_EN`): hold `btn_raw[2]`, with press at edge P → pulses at P, P+10, P+13, P+16. Release → `btn_release[2]` pulses once and there are no further presses. Without the macro: a single pulse at P only.
